// File: rtl/event_tx.sv
// Transmit side of a four-phase req/ack event crossing. Local event pulses are
// queued in a saturating counter and launched one handshake at a time.
module event_tx #(
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evt,
  input  logic             ack_async,
  output logic             req,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, ACK_LOW} state_t;

  localparam logic [CNT_W-1:0] FULL = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       pending_reg, pending_next;
  logic                   req_reg, req_next;
  logic                   done_reg, done_next;
  logic                   overflow_reg, overflow_next;
  logic                   busy_reg, busy_next;
  logic                   ack_s;
  logic                   work;
  logic                   launch;
  logic                   accept;
  logic                   from_pending;

  assign ack_s = sync_reg[SYNC_STAGES-1];
  assign work  = evt || (pending_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      sync_reg     <= '0;
      pending_reg  <= '0;
      req_reg      <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sync_reg     <= {sync_reg[SYNC_STAGES-2:0], ack_async};
      pending_reg  <= pending_next;
      req_reg      <= req_next;
      done_reg     <= done_next;
      overflow_reg <= overflow_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    done_next  = 1'b0;
    launch     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (work) begin
          launch     = 1'b1;
          state_next = REQ;
          req_next   = 1'b1;
        end
      end
      REQ: begin
        if (ack_s) begin
          state_next = ACK_LOW;
          req_next   = 1'b0;
        end
      end
      ACK_LOW: begin
        if (!ack_s) begin
          done_next = 1'b1;
          if (work) begin
            launch     = 1'b1;
            state_next = REQ;
            req_next   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // A launch takes this cycle's evt first, so accept and from_pending never coincide.
  always_comb begin
    from_pending  = launch && !evt;
    accept        = evt && !launch;
    overflow_next = accept && (pending_reg == FULL);
    pending_next  = pending_reg;
    if (accept && (pending_reg != FULL)) begin
      pending_next = pending_reg + ONE;
    end else if (from_pending) begin
      pending_next = pending_reg - ONE;
    end
    busy_next = (state_next != IDLE) || (pending_next != '0);
  end

  assign req      = req_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;
  assign busy     = busy_reg;
  assign pending  = pending_reg;

endmodule

// File: tb/tb_event_tx.sv
// Directed bench for event_tx: reset, loopback single/burst, overflow,
// launch coinciding with a new event, and reset in the middle of a handshake.
module tb_event_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       evt;
  logic       ack_async;
  logic       req;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [2:0] pending;

  logic loop;
  logic ack_force;
  int   checks   = 0;
  int   failures = 0;
  int   rises    = 0;
  int   dones    = 0;
  logic req_last = 1'b0;

  // Loopback returns req straight back as the acknowledge.
  assign ack_async = loop ? req : ack_force;

  always #5 clk = ~clk;

  event_tx #(.CNT_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .evt(evt), .ack_async(ack_async),
    .req(req), .busy(busy), .done(done), .overflow(overflow), .pending(pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (req && !req_last) rises++;
    if (done) dones++;
    req_last = req;
  endtask

  task automatic clear_counts();
    rises = 0;
    dones = 0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && busy; i++) step();
    check({tag, "_drained"}, busy, 0);
  endtask

  // One event with loopback: req high E0..E2, done and busy drop after E6.
  task automatic single_event(input string tag);
    logic [8:0] req_exp;
    logic [8:0] done_exp;
    logic [8:0] busy_exp;
    req_exp  = 9'b000000111;
    done_exp = 9'b001000000;
    busy_exp = 9'b000111111;
    clear_counts();
    loop = 1'b1;
    evt  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      evt = 1'b0;
      check($sformatf("%s_req_e%0d", tag, k), req, req_exp[k]);
      check($sformatf("%s_done_e%0d", tag, k), done, done_exp[k]);
      check($sformatf("%s_busy_e%0d", tag, k), busy, busy_exp[k]);
      check($sformatf("%s_pend_e%0d", tag, k), pending, 0);
    end
    check({tag, "_rises"}, rises, 1);
    check({tag, "_dones"}, dones, 1);
  endtask

  initial begin
    reset = 1'b1; evt = 1'b0; loop = 1'b0; ack_force = 1'b0;
    step();
    step();
    check("rst_req", req, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pending, 0);
    reset = 1'b0;
    step();
    check("idle_req", req, 0);

    single_event("single");

    // Burst of three: req rises after E0, E6, E12; done after E6, E12, E18.
    clear_counts();
    loop = 1'b1;
    for (int k = 0; k < 24; k++) begin
      evt = (k < 3);
      step();
      check($sformatf("burst_req_e%0d", k), req, ((k % 6) < 3) && (k < 18));
      check($sformatf("burst_done_e%0d", k), done, ((k % 6) == 0) && (k > 0) && (k <= 18));
      case (k)
        0:  check("burst_pend_e0", pending, 0);
        1:  check("burst_pend_e1", pending, 1);
        2:  check("burst_pend_e2", pending, 2);
        6:  check("burst_pend_e6", pending, 1);
        12: check("burst_pend_e12", pending, 0);
        default: ;
      endcase
    end
    evt = 1'b0;
    check("burst_rises", rises, 3);
    check("burst_dones", dones, 3);
    check("burst_busy", busy, 0);

    // Overflow: ack held low, nine back-to-back events.
    clear_counts();
    loop = 1'b0; ack_force = 1'b0;
    for (int k = 0; k < 9; k++) begin
      evt = 1'b1;
      step();
      check($sformatf("ovf_pend_e%0d", k), pending, (k == 0) ? 0 : ((k > 7) ? 7 : k));
      check($sformatf("ovf_flag_e%0d", k), overflow, (k == 8));
    end
    evt = 1'b0;
    step();
    check("ovf_flag_clear", overflow, 0);
    check("ovf_pend_hold", pending, 7);
    loop = 1'b1;
    drain("ovf");
    check("ovf_rises", rises, 8);
    check("ovf_dones", dones, 8);
    check("ovf_pend_end", pending, 0);

    // Fill to 7 pending, then land an evt on the cycle ack_s falls (E13).
    clear_counts();
    loop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      evt = 1'b1;
      step();
    end
    evt = 1'b0;
    check("sim_pend_full", pending, 7);
    loop = 1'b1;
    for (int k = 8; k <= 12; k++) step();
    check("sim_req_low", req, 0);
    check("sim_pend_pre", pending, 7);
    evt = 1'b1;
    step();
    evt = 1'b0;
    check("sim_req_relaunch", req, 1);
    check("sim_done", done, 1);
    check("sim_pend_same", pending, 7);
    check("sim_no_ovf", overflow, 0);
    drain("sim");
    check("sim_rises", rises, 9);
    check("sim_dones", dones, 9);

    // Reset while in REQ with three pending and ack high.
    loop = 1'b0; ack_force = 1'b0;
    for (int k = 0; k < 4; k++) begin
      evt = 1'b1;
      step();
    end
    evt = 1'b0;
    check("mid_pend_pre", pending, 3);
    check("mid_req_pre", req, 1);
    ack_force = 1'b1;
    reset = 1'b1;
    step();
    check("mid_req", req, 0);
    check("mid_pend", pending, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    reset = 1'b0;
    ack_force = 1'b0;
    step();
    step();
    check("mid_idle_req", req, 0);
    single_event("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_tx.md
# event_tx

Transmit end of the asynchronous-event path. It takes single-cycle event pulses in the local `clk` domain and hands each one across to a receiver in another clock domain, using a four-phase `req`/`ack` handshake. The receiver brings `req` into its domain through a two-flop synchronizer. This block brings the returned `ack` back through its own synchronizer. Events that arrive while a handshake is in flight are counted and sent later, in order; events beyond the counter's capacity are dropped and flagged.

## Interface
- `CNT_W`, default 3: width of the pending-event counter. Maximum number of queued events is `2**CNT_W - 1`.
- `SYNC_STAGES`, default 2: number of flops in the `ack_async` synchronizer. Legal values are 2 or more.
- `clk` input, 1 bit: the single clock. All state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `evt` input, 1 bit: local event strobe. Each cycle where it is high is one event.
- `ack_async` input, 1 bit: acknowledge from the remote domain. It is asynchronous to `clk` and is used only after the synchronizer.
- `req` output, 1 bit: request level to the remote domain. Driven directly by a flop, with no logic after it.
- `busy` output, 1 bit: high when state ≠ IDLE or `pending` ≠ 0.
- `done` output, 1 bit: one-cycle pulse when a handshake completes.
- `overflow` output, 1 bit: one-cycle pulse when an event is dropped.
- `pending` output, `CNT_W` bits: number of events accepted but not yet launched.

## Operation
- `ack_s` is the output of a `SYNC_STAGES`-deep flop chain on `ack_async`. The FSM uses only `ack_s`.
- FSM states:
  - **IDLE** (`req`=0): if `evt` or `pending` > 0, this is a launch. Go to REQ and set `req`=1.
  - **REQ** (`req`=1): wait until `ack_s`=1. Then set `req`=0 and go to ACK_LOW.
  - **ACK_LOW** (`req`=0): wait until `ack_s`=0. Then pulse `done`=1. In the same edge, go to REQ and set `req`=1 if `evt` or `pending` > 0; otherwise go to IDLE.
- Pending counter update: `pending_next = pending + accept − launch_from_pending`.
  - A launch consumes the current-cycle `evt` first. If there is no `evt`, it consumes one event from `pending`.
  - `accept` = `evt` and the event is not consumed by a launch this cycle.
- Saturation: if `pending` = `2**CNT_W - 1` and `evt` would be accepted (not consumed by a launch), the event is dropped. `pending` holds and `overflow`=1 for that cycle.
  - If `pending` is full and a launch from `pending` coincides with `evt`, net change is 0 and there is no overflow.
- Events are never merged. Each accepted event produces exactly one `req` rise.
- Reset (at any time, including mid-handshake):
  - State → IDLE; `req`, `done`, `overflow` = 0; `pending` = 0; all sync flops = 0.
  - The remote end must also be reset. Otherwise a stale `ack` high leaves this block in IDLE and the next REQ completes early.
- A glitch-free `req` is mandatory: it comes straight from a flop.

## Timing
- `evt` sampled at edge E0 while IDLE with `pending`=0: `req`=1 is visible after E0 (latency 1 edge).
- `ack_async` rising before edge Ek: `ack_s`=1 after edge Ek+`SYNC_STAGES`−1. `req` falls at the following edge.
- Loopback (`ack_async` = `req`), `SYNC_STAGES`=2, `req` rises at E0:
  - `ack_s`=1 after E2.
  - `req`=0 after E3.
  - `ack_s`=0 after E5.
  - `done` high for the cycle after E6. If work remains, `req`=1 again after E6.
  - Throughput is 1 event per 6 cycles.
- `done` and `overflow` are registered outputs, each high for exactly one cycle per occurrence.
- `busy` is registered. It is consistent with `state` and `pending` in the same cycle.

## Test plan
- **Reset:** hold `reset` 2 cycles with `ack_async`=0. All outputs are 0; `pending`=0.
- **Single event, loopback:** `evt` pulse at E0.
  - `req` 1 after E0 and 0 after E3.
  - `done` high for the single cycle after E6.
  - `busy` drops after E6.
  - Nothing further happens.
- **Burst of 3 consecutive `evt` cycles, loopback:**
  - `pending` goes 0→1→2 and does not double-count the launch cycle.
  - `req` rises after E0, E6 and E12.
  - Exactly 3 `done` pulses; `pending` ends at 0.
- **Overflow:** hold `ack_async`=0 and pulse `evt` 9 times on consecutive cycles.
  - First event launches; `pending` reaches 7.
  - 9th cycle gives `overflow`=1 and `pending` stays 7.
  - Then release loopback: exactly 8 `req` rises occur.
- **Simultaneous events:** in ACK_LOW with `pending`=7, assert `evt` on the cycle `ack_s` falls.
  - Goes directly to REQ; `pending` stays 7; no overflow.
- **Reset mid-operation:** assert `reset` while in REQ with `pending`=3 and `ack_async`=1.
  - After the edge: `req`=0, `pending`=0, state IDLE.
  - With `ack_async` then 0 and one new `evt`, normal single-event timing is restored.
